// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 radix-2 shift-add multiplier controller.
// Every partial-sum addition is performed by a shared external 32-bit adder.
module mul_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_ci,
    input  logic [31:0] add_s,
    input  logic        add_co,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_m;
    logic [PROD_W-1:0]   r_p;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;

    logic                w_add_m;
    logic [PROD_W-1:0]   w_p_step;
    logic [CNT_W-1:0]    w_cnt_inc;

    // Multiplier bit P[0] selects whether M joins this step's partial sum.
    assign w_add_m   = (r_state == S_EXEC) && r_p[0];
    assign add_a     = r_p[PROD_W-1:DATA_W];
    assign add_b     = w_add_m ? r_m : '0;
    assign add_ci    = 1'b0;

    // Carry-out lands in P[63]; the low half shifts right by one.
    assign w_p_step  = {add_co, add_s, r_p[DATA_W-1:1]};
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_start) begin
                        r_m     <= op_a;
                        r_p     <= {{DATA_W{1'b0}}, op_b};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_p   <= w_p_step;
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == LAST_ITER) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Clear wins over a simultaneous start.
                    if (op_clear) begin
                        r_p     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (op_start) begin
                        r_m     <= op_a;
                        r_p     <= {{DATA_W{1'b0}}, op_b};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_EXEC;
                    end
                end
                default: begin
                    r_p     <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_p;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl; models the external adder.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        op_start;
    logic        op_clear;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_ci;
    logic [31:0] add_s;
    logic        add_co;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks;
    int errors;

    mul_seq_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .op_start (op_start),
        .op_clear (op_clear),
        .op_a     (op_a),
        .op_b     (op_b),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_ci   (add_ci),
        .add_s    (add_s),
        .add_co   (add_co),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // External CLA adder model.
    logic [32:0] sum33;
    always_comb begin
        sum33  = 33'(add_a) + 33'(add_b) + 33'(add_ci);
        add_s  = sum33[31:0];
        add_co = sum33[32];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an operation and run until done (bounded); reports observations only.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output bit overlap, output bit seen_co,
                          output bit addb_nz, output bit got_done);
        nbusy = 0; overlap = 0; seen_co = 0; addb_nz = 0; got_done = 0;
        op_a = a; op_b = b; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy && done) overlap = 1;
            if (done) begin
                got_done = 1;
                break;
            end
            if (busy) nbusy++;
            if (add_co) seen_co = 1;
            if (add_b != 32'h0) addb_nz = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; op_start = 1'b0; op_clear = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b result=%h required 0 0 0", busy, done, result);
        end
        checks++;
        if (add_a !== 32'h0 || add_b !== 32'h0 || add_ci !== 1'b0) begin
            errors++;
            $display("FAIL reset_adder add_a=%h add_b=%h add_ci=%b required 0 0 0", add_a, add_b, add_ci);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int nb; bit ov, co, nz, gd;
        run_op(32'd7, 32'd9, nb, ov, co, nz, gd);
        checks++;
        if (nb != 32 || !gd) begin
            errors++;
            $display("FAIL basic_latency busy_cycles=%0d done=%b required 32 1", nb, gd);
        end
        checks++;
        if (result !== 64'd63) begin
            errors++;
            $display("FAIL basic_result result=%0d required 63", result);
        end
        checks++;
        if (ov) begin
            errors++;
            $display("FAIL basic_overlap busy and done both high");
        end
    endtask

    task automatic test_max;
        int nb; bit ov, co, nz, gd;
        op_clear = 1'b1; @(posedge clk); #1; op_clear = 1'b0;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, nb, ov, co, nz, gd);
        checks++;
        if (result !== 64'hFFFFFFFE00000001 || !gd) begin
            errors++;
            $display("FAIL max_result result=%h required fffffffe00000001", result);
        end
        checks++;
        if (!co) begin
            errors++;
            $display("FAIL max_carry add_co never seen high, required at least once");
        end
    endtask

    task automatic test_zero;
        int nb; bit ov, co, nz, gd;
        op_clear = 1'b1; @(posedge clk); #1; op_clear = 1'b0;
        run_op(32'h0, 32'h12345678, nb, ov, co, nz, gd);
        checks++;
        if (result !== 64'h0 || !gd) begin
            errors++;
            $display("FAIL zero_result result=%h done=%b required 0 1", result, gd);
        end
        checks++;
        if (nz) begin
            errors++;
            $display("FAIL zero_addb add_b nonzero during operation, required always 0");
        end
    endtask

    task automatic test_restart_ignored;
        int nb;
        op_clear = 1'b1; @(posedge clk); #1; op_clear = 1'b0;
        op_a = 32'd1234; op_b = 32'd5678; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (busy) nb++;
            if (i == 10) begin
                op_a = 32'd100; op_b = 32'd100; op_start = 1'b1;
            end else begin
                op_start = 1'b0;
            end
            @(posedge clk); #1;
        end
        op_start = 1'b0;
        checks++;
        if (nb != 32 || done !== 1'b1) begin
            errors++;
            $display("FAIL restart_latency busy_cycles=%0d done=%b required 32 1", nb, done);
        end
        checks++;
        if (result !== 64'd7006652) begin
            errors++;
            $display("FAIL restart_result result=%0d required 7006652", result);
        end
    endtask

    task automatic test_reset_mid;
        int nb; bit ov, co, nz, gd;
        op_clear = 1'b1; @(posedge clk); #1; op_clear = 1'b0;
        op_a = 32'hDEAD; op_b = 32'hBEEF; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre busy=%b required 1", busy);
        end
        reset = 1'b1; op_start = 1'b1; op_clear = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; op_start = 1'b0; op_clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0 || add_a !== 32'h0 || add_b !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs busy=%b done=%b result=%h add_a=%h add_b=%h required all 0",
                     busy, done, result, add_a, add_b);
        end
        run_op(32'd3, 32'd5, nb, ov, co, nz, gd);
        checks++;
        if (result !== 64'd15 || nb != 32 || !gd) begin
            errors++;
            $display("FAIL midreset_followup result=%0d busy_cycles=%0d required 15 32", result, nb);
        end
    endtask

    task automatic test_clear_priority;
        op_a = 32'd9; op_b = 32'd9; op_start = 1'b1; op_clear = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0; op_clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL clear_priority busy=%b done=%b result=%h required 0 0 0", busy, done, result);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle_stays busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int nb; bit ov, co, nz, gd;
        run_op(32'd6, 32'd7, nb, ov, co, nz, gd);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 64'd42) begin
            errors++;
            $display("FAIL done_hold done=%b busy=%b result=%0d required 1 0 42", done, busy, result);
        end
        run_op(32'd2, 32'd2, nb, ov, co, nz, gd);
        checks++;
        if (result !== 64'd4 || nb != 32 || !gd) begin
            errors++;
            $display("FAIL done_restart result=%0d busy_cycles=%0d required 4 32", result, nb);
        end
        op_clear = 1'b1; @(posedge clk); #1; op_clear = 1'b0;
        checks++;
        if (done !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL clear_only done=%b result=%h required 0 0", done, result);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_restart_ignored();
        test_reset_mid();
        test_clear_priority();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_start  input  1  request to begin a multiply; sampled only in IDLE and DONE.
REQ-005 op_clear  input  1  return from DONE to IDLE; ignored in other states.
REQ-006 op_a  input  32  unsigned multiplicand; latched on start acceptance.
REQ-007 op_b  input  32  unsigned multiplier; latched on start acceptance.
REQ-008 add_a  output  32  operand A to the shared external 32-bit CLA adder.
REQ-009 add_b  output  32  operand B to the shared external adder.
REQ-010 add_ci  output  1  carry-in to the shared external adder; constant 0.
REQ-011 add_s  input  32  sum returned by the external adder (combinational path).
REQ-012 add_co  input  1  carry-out returned by the external adder.
REQ-013 busy  output  1  high while in EXEC.
REQ-014 done  output  1  high while in DONE; result is valid.
REQ-015 result  output  64  product register P.

Function
REQ-016 The block SHALL implement radix-2 unsigned shift-add using the external adder for every partial-sum addition, and SHALL contain no internal adder of 32 bits or wider.
REQ-017 The block SHALL use three states, IDLE, EXEC and DONE, plus a 6-bit iteration counter cnt.
REQ-018 IDLE with op_start=1: at the edge, M<=op_a, P<={32'h0,op_b}, cnt<=0, state<=EXEC.
REQ-019 Start acceptance from DONE: op_start=1 with op_clear=0 in DONE SHALL behave identically to REQ-018.
REQ-020 Adder drive: add_a=P[63:32] in every state; add_b=M when state=EXEC and P[0]=1, else 32'h0; add_ci=0.
REQ-021 EXEC, each edge: P<={add_co, add_s, P[31:1]}, and cnt<=cnt+1.
REQ-022 EXEC exit: on the edge where cnt=31, the final update SHALL occur and state<=DONE.
REQ-023 Latency: exactly 32 EXEC cycles. If start is accepted at edge T, busy=1 after edges T..T+31 and done=1 after edge T+32.
REQ-024 op_start and changes to op_a/op_b during EXEC SHALL be ignored. M is stable for the whole operation.
REQ-025 DONE SHALL hold P and done=1 indefinitely until op_clear or op_start is sampled.
REQ-026 DONE with op_clear=1: state<=IDLE and P<=0. op_clear has priority over a simultaneous op_start.
REQ-027 busy and done SHALL never be high together, and SHALL both be low in IDLE.
REQ-028 The 64-bit product SHALL never overflow. Carry out of each step SHALL enter P[63] and SHALL never be dropped.
REQ-029 During EXEC, result SHALL show the intermediate P. Consumers qualify result with done.

Reset
REQ-030 reset=1 at an edge SHALL force state=IDLE, P=0, M=0, cnt=0, busy=0, done=0, result=0, regardless of state, including mid-EXEC.
REQ-031 reset SHALL take priority over op_start and op_clear sampled at the same edge.
REQ-032 After reset is released, op_start SHALL be accepted on the first edge with reset=0.

Verification
REQ-033 op_a=7, op_b=9, pulse op_start -> busy for 32 cycles, then done=1 and result=64'd63.
REQ-034 op_a=op_b=32'hFFFFFFFF -> result=64'hFFFFFFFE00000001 after 32 cycles; add_co=1 observed on at least one step.
REQ-035 op_a=0, op_b=32'h12345678 -> result=0, and add_b=0 on every cycle.
REQ-036 op_start re-pulsed at cycle 10 of EXEC with new operands -> ignored; the original product is returned at cycle 32.
REQ-037 reset asserted at cycle 15 of EXEC -> all outputs 0 on the next cycle; a following 3x5 operation yields 15.
REQ-038 In DONE, op_start=1 and op_clear=1 together -> IDLE, result=0, no new operation; then op_start alone from DONE with 2x2 -> result=4 after 32 cycles.
